axi_decerr_sub: RTL
===================

Name: axi_decerr_sub

Overview:
- Default subordinate (responder) for the AXI crossbar. Sits behind the demux on the "no rule matched" port.
- Terminates every transaction routed to it with a DECERR response and generates all protocol-correct handshakes: write data is drained, B is returned, R bursts carry the correct beat count and RLAST.
- Supports AXI5 ATOP, including atomics that require an R response.

Parameters:
- IdWidth, 4, width of AW/AR/B/R ID fields.
- DataWidth, 64, width of R data.
- RespData, 64'hBADC_AB1E_DEAD_BEEF, constant driven on r_data_o; truncated to DataWidth.
- ErrResp, 2'b11, response code driven on b_resp_o/r_resp_o (DECERR). RespWidth is 2.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- aw_id_i, in, IdWidth, write address ID.
- aw_len_i, in, 8 (LenWidth), burst length minus 1; used only for atomic R beats.
- aw_atop_i, in, 6 (AtopWidth), atomic opcode.
- aw_valid_i, in, 1, AW valid.
- aw_ready_o, out, 1, AW ready.
- w_last_i, in, 1, last write beat.
- w_valid_i, in, 1, W valid.
- w_ready_o, out, 1, W ready.
- b_id_o, out, IdWidth, B ID.
- b_resp_o, out, 2, B response.
- b_valid_o, out, 1, B valid.
- b_ready_i, in, 1, B ready.
- ar_id_i, in, IdWidth, read address ID.
- ar_len_i, in, 8, read burst length minus 1.
- ar_valid_i, in, 1, AR valid.
- ar_ready_o, out, 1, AR ready.
- r_id_o, out, IdWidth, R ID.
- r_data_o, out, DataWidth, R data.
- r_resp_o, out, 2, R response.
- r_last_o, out, 1, last read beat.
- r_valid_o, out, 1, R valid.
- r_ready_i, in, 1, R ready.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state: both FSMs idle, atop_pend=0, beat counter=0, latched IDs=0.
- Reset output values:
  - aw_ready_o=1 and ar_ready_o=1 in the first cycle after reset deasserts; 0 while rst_i=1.
  - All valid outputs, r_last_o, w_ready_o, b_id_o and r_id_o are 0.
  - b_resp_o and r_resp_o are constant ErrResp; r_data_o is constant RespData.
- Write FSM, states W_IDLE -> W_DRAIN -> W_RESP -> W_IDLE:
  - W_IDLE: aw_ready_o = !atop_pend.
    - On AW handshake: latch aw_id_i and aw_len_i, go to W_DRAIN.
    - If aw_atop_i[5]=1 (atomic with read response), also set atop_pend.
  - W_DRAIN: w_ready_o=1. Every W beat is accepted and discarded. On a handshake with w_last_i=1, go to W_RESP.
  - W_RESP: b_valid_o=1, b_id_o=latched ID. Hold until b_ready_i=1, then go to W_IDLE.
  - B is never withdrawn before its handshake.
- Read FSM, states R_IDLE -> R_BURST -> R_IDLE:
  - R_IDLE, atop_pend=1: ar_ready_o=0. Load ID and len from the latched AW, clear atop_pend, go to R_BURST. The atomic always wins over a waiting AR.
  - R_IDLE, atop_pend=0: ar_ready_o=1. On AR handshake, load ar_id_i/ar_len_i and go to R_BURST.
  - R_BURST: r_valid_o=1, r_last_o=(cnt==0).
    - On an R handshake with cnt!=0: cnt decrements.
    - On an R handshake with cnt==0: go to R_IDLE.
- Counter: 8 bits, loaded with len. A burst produces exactly len+1 beats; len=255 gives 256 beats with no wrap.
- Latency:
  - AW handshake at cycle N: w_ready_o=1 at N+1.
  - W-last handshake at N: b_valid_o at N+1.
  - AR handshake at N: first R beat valid at N+1.
  - Full throughput: one beat per cycle in W_DRAIN and R_BURST.
- Concurrency: one outstanding write and one outstanding read. The write and read FSMs run independently, except for the atop_pend handoff. The atomic R burst and B response may overlap in any order.
- Simultaneous events:
  - A W beat with w_last presented in the same cycle as its AW is not accepted (w_ready_o=0 in W_IDLE). It is accepted on a later cycle.
  - AR valid in the same cycle atop_pend is set: the AR is accepted (atop_pend is not yet visible). The atomic R burst follows after that burst completes.
- Reset mid-operation: the transaction in flight is abandoned. All valids drop the cycle rst_i is sampled high, and nothing is replayed.

Test Plan:
- Write: AW id=3, len=3, atop=0; 4 W beats, last on the 4th -> exactly 4 W handshakes, then B id=3, resp=2'b11 one cycle after the last beat; aw_ready_o=0 until the B handshake.
- Read: AR id=5, len=0 -> single R beat, id=5, resp=3, last=1, data=RespData. AR id=6, len=255 with r_ready_i toggling 50% -> 256 beats, r_last_o only on the 256th.
- Atomic: AW id=2, len=1, atop=6'b100000 with an AR id=7 pending the following cycle -> B id=2; 2 R beats id=2 issued before any R for id 7; ar_ready_o=0 until the atomic burst starts.
- Backpressure: b_ready_i=0 for 10 cycles -> b_valid_o and b_id_o stable; no new AW accepted.
- Reset asserted mid-R burst at beat 3 of 8 -> r_valid_o=0 from that cycle; after release, a new AR len=1 yields exactly 2 beats.

Source files
------------

// File: rtl/axi_decerr_if.sv
// AXI subset seen by the default (decode-error) subordinate. Signal suffixes are
// from the subordinate's point of view, so the same names work on both modports.
interface axi_decerr_if #(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned DataWidth = 64
);
   logic [IdWidth-1:0]   aw_id_i;
   logic [7:0]           aw_len_i;
   logic [5:0]           aw_atop_i;
   logic                 aw_valid_i;
   logic                 aw_ready_o;

   logic                 w_last_i;
   logic                 w_valid_i;
   logic                 w_ready_o;

   logic [IdWidth-1:0]   b_id_o;
   logic [1:0]           b_resp_o;
   logic                 b_valid_o;
   logic                 b_ready_i;

   logic [IdWidth-1:0]   ar_id_i;
   logic [7:0]           ar_len_i;
   logic                 ar_valid_i;
   logic                 ar_ready_o;

   logic [IdWidth-1:0]   r_id_o;
   logic [DataWidth-1:0] r_data_o;
   logic [1:0]           r_resp_o;
   logic                 r_last_o;
   logic                 r_valid_o;
   logic                 r_ready_i;

   modport slv (
      input  aw_id_i, aw_len_i, aw_atop_i, aw_valid_i,
      output aw_ready_o,
      input  w_last_i, w_valid_i,
      output w_ready_o,
      output b_id_o, b_resp_o, b_valid_o,
      input  b_ready_i,
      input  ar_id_i, ar_len_i, ar_valid_i,
      output ar_ready_o,
      output r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o,
      input  r_ready_i
   );

   modport mst (
      output aw_id_i, aw_len_i, aw_atop_i, aw_valid_i,
      input  aw_ready_o,
      output w_last_i, w_valid_i,
      input  w_ready_o,
      input  b_id_o, b_resp_o, b_valid_o,
      output b_ready_i,
      output ar_id_i, ar_len_i, ar_valid_i,
      input  ar_ready_o,
      input  r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o,
      output r_ready_i
   );
endinterface

// File: rtl/axi_decerr_sub.sv
// Default AXI subordinate: answers every transaction with DECERR, drains write
// data, and returns correctly sized R bursts, including R data for ATOP atomics.
module axi_decerr_sub #(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned DataWidth = 64,
   parameter logic [63:0] RespData  = 64'hBADC_AB1E_DEAD_BEEF,
   parameter logic [1:0]  ErrResp   = 2'b11
) (
   input logic       clk_i,
   input logic       rst_i,
   axi_decerr_if.slv bus
);

   localparam int unsigned LenWidth = 8;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DRAIN,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_BURST
   } r_state_e;

   w_state_e              w_state_q, w_state_d;
   r_state_e              r_state_q, r_state_d;
   logic [IdWidth-1:0]    aw_id_q, aw_id_d;
   logic [LenWidth-1:0]   aw_len_q, aw_len_d;
   logic                  atop_pend_q, atop_pend_d;
   logic [IdWidth-1:0]    r_id_q, r_id_d;
   logic [LenWidth-1:0]   cnt_q, cnt_d;

   logic                  atop_set, atop_clr;
   logic                  aw_ready, w_ready, b_valid;
   logic                  ar_ready, r_valid, r_last;

   // Only the "atomic with read response" bit of ATOP matters here.
   logic                  unused_atop;
   assign unused_atop = ^bus.aw_atop_i[4:0];

   // ---------------------------------------------------------------------------
   // Write side: accept AW, swallow W until last, return one B.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis infers a latch to hold the old value.
      w_state_d = w_state_q;
      aw_id_d   = aw_id_q;
      aw_len_d  = aw_len_q;
      atop_set  = 1'b0;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;

      unique case (w_state_q)
         W_IDLE: begin
            // An atomic still waiting to hand its ID to the read side blocks new AWs,
            // which keeps aw_id_q/aw_len_q valid until the read FSM copies them.
            aw_ready = !atop_pend_q;
            if (bus.aw_valid_i && aw_ready) begin
               aw_id_d   = bus.aw_id_i;
               aw_len_d  = bus.aw_len_i;
               atop_set  = bus.aw_atop_i[5];
               w_state_d = W_DRAIN;
            end
         end
         W_DRAIN: begin
            w_ready = 1'b1;
            if (bus.w_valid_i && bus.w_last_i) begin
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (bus.b_ready_i) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Read side: a pending atomic takes priority over a waiting AR.
   // ---------------------------------------------------------------------------
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      cnt_d     = cnt_q;
      atop_clr  = 1'b0;
      ar_ready  = 1'b0;
      r_valid   = 1'b0;
      r_last    = 1'b0;

      unique case (r_state_q)
         R_IDLE: begin
            if (atop_pend_q) begin
               r_id_d    = aw_id_q;
               cnt_d     = aw_len_q;
               atop_clr  = 1'b1;
               r_state_d = R_BURST;
            end else begin
               ar_ready = 1'b1;
               if (bus.ar_valid_i) begin
                  r_id_d    = bus.ar_id_i;
                  cnt_d     = bus.ar_len_i;
                  r_state_d = R_BURST;
               end
            end
         end
         R_BURST: begin
            r_valid = 1'b1;
            r_last  = (cnt_q == '0);
            if (bus.r_ready_i) begin
               if (cnt_q == '0) begin
                  r_state_d = R_IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Set (write side, W_IDLE only) and clear (read side, while pending) never coincide.
   assign atop_pend_d = (atop_pend_q | atop_set) & ~atop_clr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q   <= W_IDLE;
         r_state_q   <= R_IDLE;
         aw_id_q     <= '0;
         aw_len_q    <= '0;
         atop_pend_q <= 1'b0;
         r_id_q      <= '0;
         cnt_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments let every register sample the
         // pre-edge value of the others, independent of statement order.
         w_state_q   <= w_state_d;
         r_state_q   <= r_state_d;
         aw_id_q     <= aw_id_d;
         aw_len_q    <= aw_len_d;
         atop_pend_q <= atop_pend_d;
         r_id_q      <= r_id_d;
         cnt_q       <= cnt_d;
      end
   end

   // Handshake outputs are gated by reset so they drop in the very cycle reset is seen.
   assign bus.aw_ready_o = aw_ready & ~rst_i;
   assign bus.w_ready_o  = w_ready  & ~rst_i;
   assign bus.b_valid_o  = b_valid  & ~rst_i;
   assign bus.ar_ready_o = ar_ready & ~rst_i;
   assign bus.r_valid_o  = r_valid  & ~rst_i;
   assign bus.r_last_o   = r_last   & ~rst_i;

   assign bus.b_id_o     = aw_id_q;
   assign bus.b_resp_o   = ErrResp;
   assign bus.r_id_o     = r_id_q;
   assign bus.r_resp_o   = ErrResp;
   assign bus.r_data_o   = RespData[DataWidth-1:0];

endmodule
